// File: rtl/cmp_sort_if.sv
// cmp_sort_if: job control, load stream and result stream of cmp_sort_ctrl.
//
// Handshake: a transfer happens on a rising clock edge where both valid and
// ready are high. The producer holds valid and data steady until that edge.
// The consumer may change ready at any time. The din stream uses
// din_valid/din_ready and the dout stream uses dout_valid/dout_ready. start is
// a plain request that is only looked at while the block is idle.
interface cmp_sort_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             din_valid;
   logic [WIDTH-1:0] din;
   logic             din_ready;
   logic             dout_valid;
   logic [WIDTH-1:0] dout;
   logic             dout_ready;
   logic             busy;
   logic             done;
   logic [7:0]       swaps;

   // The environment drives the job, the load data and dout_ready.
   modport master (
      output start, din_valid, din, dout_ready,
      input  din_ready, dout_valid, dout, busy, done, swaps
   );

   // The sorter.
   modport slave (
      input  start, din_valid, din, dout_ready,
      output din_ready, dout_valid, dout, busy, done, swaps
   );
endinterface

// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: loads N_ENTRIES values, bubble-sorts them into ascending
// order with one shared magnitude comparator, then streams them out.
// The optional macro CMP_SORT_EARLY_EXIT_EN ends SORT after a pass that made
// no swaps. Without the macro, SORT always runs N_ENTRIES-1 full passes.
// state_dbg shows the FSM state and cmp_dbg shows the comparator flags
// {great, equal, less}.
module cmp_sort_ctrl #(
   parameter int N_ENTRIES = 4,
   parameter int WIDTH     = 4
) (
   input  logic        clk,
   input  logic        rst,
   cmp_sort_if.slave   bus,
   output logic [1:0]  state_dbg,
   output logic [2:0]  cmp_dbg
);
   localparam int IW = (N_ENTRIES > 2) ? $clog2(N_ENTRIES) : 1;
   localparam logic [IW-1:0] LAST_IDX  = IW'(N_ENTRIES - 1);
   localparam logic [IW-1:0] LAST_CMP  = IW'(N_ENTRIES - 2);
   localparam logic [IW-1:0] LAST_PASS = IW'(N_ENTRIES - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SORT = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t           state;
   logic [IW-1:0]    wr_idx;
   logic [IW-1:0]    rd_idx;
   logic [IW-1:0]    cmp_idx;
   logic [IW-1:0]    pass_idx;
   logic             pass_swapped;
   logic             din_ready_r;
   logic             dout_valid_r;
   logic [WIDTH-1:0] dout_r;
   logic             busy_r;
   logic             done_r;
   logic [7:0]       swaps_r;

   // Entry storage has no reset. Stale contents are never visible because
   // every job rewrites all entries before it reads any of them.
   logic [WIDTH-1:0] ent [N_ENTRIES];

   logic [IW-1:0]    cmp_hi;
   logic [IW-1:0]    rd_nxt;
   logic [WIDTH-1:0] cmp_a;
   logic [WIDTH-1:0] cmp_b;
   logic             great;
   logic             equal;
   logic             less;
   logic             load_fire;
   logic             out_fire;
   logic             last_cmp;
   logic             pass_had_swap;
   logic             sort_end;
   logic             do_swap;
   logic [WIDTH-1:0] dout_first;

   // This is the single comparator. It always looks at the pair (cmp_idx, cmp_idx+1).
   always_comb begin
      cmp_hi = cmp_idx + IW'(1);
      rd_nxt = rd_idx + IW'(1);
      cmp_a  = ent[cmp_idx];
      cmp_b  = ent[cmp_hi];
      great  = (cmp_a > cmp_b);
      equal  = (cmp_a == cmp_b);
      less   = (cmp_a < cmp_b);
   end

   assign load_fire     = (state == LOAD) && bus.din_valid && din_ready_r;
   assign out_fire      = (state == OUT) && dout_valid_r && bus.dout_ready;
   assign do_swap       = (state == SORT) && great;
   assign last_cmp      = (cmp_idx == LAST_CMP);
   assign pass_had_swap = pass_swapped | great;

   // This decides when sorting stops, which is always at the last compare of a pass.
`ifdef CMP_SORT_EARLY_EXIT_EN
   assign sort_end = last_cmp && ((pass_idx == LAST_PASS) || !pass_had_swap);
`else
   assign sort_end = last_cmp && (pass_idx == LAST_PASS);
`endif

   // Entry 0 as it will look after this edge. Only the pair (0,1) can change it.
   assign dout_first = (great && (cmp_idx == '0)) ? cmp_b : ent[0];

   // This writes the entry storage. It loads values in LOAD and swaps the compared pair in SORT.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (load_fire) begin
            ent[wr_idx] <= bus.din;
         end else if (do_swap) begin
            ent[cmp_idx] <= cmp_b;
            ent[cmp_hi]  <= cmp_a;
         end
      end
   end

   // This is the control FSM. It also registers every output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         wr_idx       <= '0;
         rd_idx       <= '0;
         cmp_idx      <= '0;
         pass_idx     <= '0;
         pass_swapped <= 1'b0;
         din_ready_r  <= 1'b0;
         dout_valid_r <= 1'b0;
         dout_r       <= '0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         swaps_r      <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state       <= LOAD;
                  wr_idx      <= '0;
                  swaps_r     <= '0;
                  busy_r      <= 1'b1;
                  din_ready_r <= 1'b1;
               end
            end
            LOAD: begin
               if (load_fire) begin
                  if (wr_idx == LAST_IDX) begin
                     state        <= SORT;
                     wr_idx       <= '0;
                     din_ready_r  <= 1'b0;
                     cmp_idx      <= '0;
                     pass_idx     <= '0;
                     pass_swapped <= 1'b0;
                  end else begin
                     wr_idx <= wr_idx + IW'(1);
                  end
               end
            end
            SORT: begin
               if (great && (swaps_r != 8'hFF)) begin
                  swaps_r <= swaps_r + 8'd1;
               end
               if (sort_end) begin
                  state        <= OUT;
                  dout_valid_r <= 1'b1;
                  dout_r       <= dout_first;
                  rd_idx       <= '0;
                  cmp_idx      <= '0;
               end else if (last_cmp) begin
                  cmp_idx      <= '0;
                  pass_idx     <= pass_idx + IW'(1);
                  pass_swapped <= 1'b0;
               end else begin
                  cmp_idx      <= cmp_hi;
                  pass_swapped <= pass_had_swap;
               end
            end
            OUT: begin
               if (out_fire) begin
                  if (rd_idx == LAST_IDX) begin
                     state        <= IDLE;
                     dout_valid_r <= 1'b0;
                     busy_r       <= 1'b0;
                     done_r       <= 1'b1;
                     rd_idx       <= '0;
                  end else begin
                     rd_idx <= rd_nxt;
                     dout_r <= ent[rd_nxt];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.din_ready  = din_ready_r;
   assign bus.dout_valid = dout_valid_r;
   assign bus.dout       = dout_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.swaps      = swaps_r;
   assign state_dbg      = state;
   assign cmp_dbg        = {great, equal, less};
endmodule
